// File: rtl/hazard_stall_unit.sv
// Load-use hazard detector: tracks outstanding loads per register with saturating
// 2-bit counters and stalls the ID stage until the producing load has written back.
module hazard_stall_unit #(
    parameter int NREG = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       rs_id,
    input  logic [3:0]       rt_id,
    input  logic [3:0]       rd_id,
    input  logic             use_rs_id,
    input  logic             use_rt_id,
    input  logic             use_rd_id,
    input  logic             valid_id,
    input  logic             flush_id,
    input  logic             rf_wen_id,
    input  logic             mem2reg_id,
    input  logic [3:0]       rf_waddr_id,
    input  logic             rf_wen_memwb,
    input  logic             mem2reg_memwb,
    input  logic [3:0]       rf_waddr_memwb,
    output logic             stall,
    output logic             bubble_idex,
    output logic [NREG-1:0]  pending_mask,
    output logic [15:0]      stall_count,
    output logic             sb_err
);

    logic [15:0] busy;
    logic [15:0] err_vec;
    logic        hit_rs, hit_rt, hit_rd;
    logic        hazard;
    logic        issue;
    logic        retire;
    logic        sb_err_q, sb_err_d;
    logic [15:0] stall_count_q, stall_count_d;

    assign hit_rs = use_rs_id & (rs_id != 4'd0) & busy[rs_id];
    assign hit_rt = use_rt_id & (rt_id != 4'd0) & busy[rt_id];
    assign hit_rd = use_rd_id & (rd_id != 4'd0) & busy[rd_id];

    assign hazard = valid_id & ~flush_id & (hit_rs | hit_rt | hit_rd);
    assign issue  = valid_id & ~flush_id & ~hazard & rf_wen_id & mem2reg_id
                    & (rf_waddr_id != 4'd0);
    assign retire = rf_wen_memwb & mem2reg_memwb & (rf_waddr_memwb != 4'd0);

    assign stall       = rst_n & hazard;
    assign bubble_idex = stall;

    assign pending_mask[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_slot
            if (gi >= 1 && gi < NREG) begin : g_reg
                logic [1:0] cnt_q, cnt_d;
                logic       pend_q;
                logic       inc, dec, err;

                assign inc = issue  & (rf_waddr_id    == 4'(gi));
                assign dec = retire & (rf_waddr_memwb == 4'(gi));

                // A same-cycle issue and retire on one register cancel out.
                always_comb begin
                    cnt_d = cnt_q;
                    err   = 1'b0;
                    if (inc && !dec) begin
                        if (cnt_q == 2'd3) err = 1'b1;
                        else               cnt_d = cnt_q + 2'd1;
                    end else if (dec && !inc) begin
                        if (cnt_q == 2'd0) err = 1'b1;
                        else               cnt_d = cnt_q - 2'd1;
                    end
                end

                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        cnt_q  <= 2'd0;
                        pend_q <= 1'b0;
                    end else begin
                        cnt_q  <= cnt_d;
                        pend_q <= (cnt_d != 2'd0);
                    end
                end

                assign busy[gi]         = (cnt_q != 2'd0);
                assign err_vec[gi]      = err;
                assign pending_mask[gi] = pend_q;
            end else begin : g_none
                assign busy[gi]    = 1'b0;
                assign err_vec[gi] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        sb_err_d      = sb_err_q | (|err_vec);
        stall_count_d = stall_count_q;
        if (stall && stall_count_q != 16'hFFFF)
            stall_count_d = stall_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sb_err_q      <= 1'b0;
            stall_count_q <= 16'd0;
        end else begin
            sb_err_q      <= sb_err_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign sb_err      = sb_err_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: directed vector table for the corner cases, then
// randomized traffic checked against a per-register outstanding-load model.
module tb_hazard_stall_unit;

    localparam int NREG = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [3:0]  rs_id, rt_id, rd_id;
    logic        use_rs_id, use_rt_id, use_rd_id;
    logic        valid_id, flush_id;
    logic        rf_wen_id, mem2reg_id;
    logic [3:0]  rf_waddr_id;
    logic        rf_wen_memwb, mem2reg_memwb;
    logic [3:0]  rf_waddr_memwb;
    logic        stall, bubble_idex;
    logic [NREG-1:0] pending_mask;
    logic [15:0] stall_count;
    logic        sb_err;

    hazard_stall_unit #(.NREG(NREG)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rs_id          (rs_id),
        .rt_id          (rt_id),
        .rd_id          (rd_id),
        .use_rs_id      (use_rs_id),
        .use_rt_id      (use_rt_id),
        .use_rd_id      (use_rd_id),
        .valid_id       (valid_id),
        .flush_id       (flush_id),
        .rf_wen_id      (rf_wen_id),
        .mem2reg_id     (mem2reg_id),
        .rf_waddr_id    (rf_waddr_id),
        .rf_wen_memwb   (rf_wen_memwb),
        .mem2reg_memwb  (mem2reg_memwb),
        .rf_waddr_memwb (rf_waddr_memwb),
        .stall          (stall),
        .bubble_idex    (bubble_idex),
        .pending_mask   (pending_mask),
        .stall_count    (stall_count),
        .sb_err         (sb_err)
    );

    typedef struct {
        bit       rn, vl, fl;
        bit [3:0] rs, rt, rd;
        bit       urs, urt, urd;
        bit       wen, m2r;
        bit [3:0] wa;
        bit       wen_wb, m2r_wb;
        bit [3:0] wa_wb;
        bit       exp_stall;
        bit [15:0] exp_mask;
        bit       exp_err;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Reference state: number of loads in flight per register.
    int cnt_m [16];
    int sc_m;
    bit err_m;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit reads_pending(input logic u, input logic [3:0] r);
        return u && (r != 4'd0) && (cnt_m[r] > 0);
    endfunction

    function automatic bit model_stall();
        return rst_n && valid_id && !flush_id &&
               (reads_pending(use_rs_id, rs_id) || reads_pending(use_rt_id, rt_id) ||
                reads_pending(use_rd_id, rd_id));
    endfunction

    function automatic logic [15:0] model_mask();
        logic [15:0] m = '0;
        for (int r = 1; r < 16; r++)
            if (cnt_m[r] != 0) m[r] = 1'b1;
        return m;
    endfunction

    task automatic model_edge(input bit st);
        bit iss, ret;
        int wa, wb;
        if (!rst_n) begin
            for (int r = 0; r < 16; r++) cnt_m[r] = 0;
            sc_m  = 0;
            err_m = 0;
        end else begin
            wa  = int'(rf_waddr_id);
            wb  = int'(rf_waddr_memwb);
            iss = valid_id && !flush_id && !st && rf_wen_id && mem2reg_id && wa != 0;
            ret = rf_wen_memwb && mem2reg_memwb && wb != 0;
            if (!(iss && ret && wa == wb)) begin
                if (iss) begin
                    if (cnt_m[wa] == 3) err_m = 1;
                    else cnt_m[wa] = cnt_m[wa] + 1;
                end
                if (ret) begin
                    if (cnt_m[wb] == 0) err_m = 1;
                    else cnt_m[wb] = cnt_m[wb] - 1;
                end
            end
            if (st && sc_m < 65535) sc_m = sc_m + 1;
        end
    endtask

    task automatic drive(input vec_t t);
        rst_n          = t.rn;
        valid_id       = t.vl;
        flush_id       = t.fl;
        rs_id          = t.rs;
        rt_id          = t.rt;
        rd_id          = t.rd;
        use_rs_id      = t.urs;
        use_rt_id      = t.urt;
        use_rd_id      = t.urd;
        rf_wen_id      = t.wen;
        mem2reg_id     = t.m2r;
        rf_waddr_id    = t.wa;
        rf_wen_memwb   = t.wen_wb;
        mem2reg_memwb  = t.m2r_wb;
        rf_waddr_memwb = t.wa_wb;
    endtask

    // Inputs are applied at the falling edge; combinational outputs are sampled
    // 1ns later and registered outputs 1ns after the rising edge.
    task automatic step(output logic st_got);
        bit est;
        #1;
        est    = model_stall();
        st_got = stall;
        chk("stall", 32'(stall), 32'(est));
        chk("bubble_idex", 32'(bubble_idex), 32'(est));
        @(posedge clk);
        model_edge(est);
        #1;
        chk("pending_mask", 32'(pending_mask), 32'(model_mask()));
        chk("stall_count", 32'(stall_count), 32'(sc_m));
        chk("sb_err", 32'(sb_err), 32'(err_m));
    endtask

    function automatic vec_t mk(input int rn, input int vl, input int fl,
                                input int rs, input int urs, input int rd, input int urd,
                                input int ld, input int wa, input int ret, input int wb,
                                input int es, input int em, input int ee);
        vec_t t;
        t.rn = (rn != 0);   t.vl = (vl != 0);   t.fl = (fl != 0);
        t.rs = 4'(rs);      t.urs = (urs != 0);
        t.rt = 4'hF;        t.urt = 1'b0;
        t.rd = 4'(rd);      t.urd = (urd != 0);
        t.wen = (ld != 0);  t.m2r = (ld != 0);  t.wa = 4'(wa);
        t.wen_wb = (ret != 0); t.m2r_wb = (ret != 0); t.wa_wb = 4'(wb);
        t.exp_stall = (es != 0);
        t.exp_mask  = 16'(em);
        t.exp_err   = (ee != 0);
        return t;
    endfunction

    vec_t tbl[$];
    vec_t rv;
    logic st;

    initial begin
        for (int r = 0; r < 16; r++) cnt_m[r] = 0;
        sc_m  = 0;
        err_m = 0;

        // Reset applied from time zero, before the first rising edge.
        drive(mk(0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0));
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            step(st);
        end

        // load-use on r3 with ID->EX->MEM->WB spacing
        tbl.push_back(mk(1,1,0, 0,0,0,0, 1,3, 0,0, 0,'h0008,0));
        tbl.push_back(mk(1,1,0, 3,1,0,0, 0,0, 0,0, 1,'h0008,0));
        tbl.push_back(mk(1,1,0, 3,1,0,0, 0,0, 0,0, 1,'h0008,0));
        tbl.push_back(mk(1,1,0, 3,1,0,0, 0,0, 1,3, 1,'h0000,0));
        tbl.push_back(mk(1,1,0, 3,1,0,0, 0,0, 0,0, 0,'h0000,0));
        // r0 is never tracked
        tbl.push_back(mk(1,1,0, 0,0,0,0, 1,0, 0,0, 0,'h0000,0));
        tbl.push_back(mk(1,1,0, 0,1,0,0, 0,0, 0,0, 0,'h0000,0));
        // same-cycle issue/retire
        tbl.push_back(mk(1,1,0, 0,0,0,0, 1,5, 0,0, 0,'h0020,0));
        tbl.push_back(mk(1,1,0, 0,0,0,0, 1,5, 1,5, 0,'h0020,0));
        tbl.push_back(mk(1,1,0, 0,0,0,0, 1,6, 0,0, 0,'h0060,0));
        tbl.push_back(mk(1,1,0, 0,0,0,0, 1,5, 1,6, 0,'h0020,0));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0, 1,5, 0,'h0020,0));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0, 1,5, 0,'h0000,0));
        // flush masks a store-data hazard and suppresses issue
        tbl.push_back(mk(1,1,0, 0,0,0,0, 1,7, 0,0, 0,'h0080,0));
        tbl.push_back(mk(1,1,1, 0,0,7,1, 1,8, 0,0, 0,'h0080,0));
        tbl.push_back(mk(1,1,0, 0,0,7,1, 0,0, 0,0, 1,'h0080,0));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0, 1,7, 0,'h0000,0));
        // underflow error, sticky
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0, 1,9, 0,'h0000,1));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0, 0,0, 0,'h0000,1));
        // reset, then overflow on r2 and drain three
        tbl.push_back(mk(0,0,0, 0,0,0,0, 0,0, 0,0, 0,'h0000,0));
        tbl.push_back(mk(1,1,0, 0,0,0,0, 1,2, 0,0, 0,'h0004,0));
        tbl.push_back(mk(1,1,0, 0,0,0,0, 1,2, 0,0, 0,'h0004,0));
        tbl.push_back(mk(1,1,0, 0,0,0,0, 1,2, 0,0, 0,'h0004,0));
        tbl.push_back(mk(1,1,0, 0,0,0,0, 1,2, 0,0, 0,'h0004,1));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0, 1,2, 0,'h0004,1));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0, 1,2, 0,'h0004,1));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0, 1,2, 0,'h0000,1));
        // reset in the middle of a stall
        tbl.push_back(mk(1,1,0, 0,0,0,0, 1,4, 0,0, 0,'h0010,1));
        tbl.push_back(mk(1,1,0, 4,1,0,0, 0,0, 0,0, 1,'h0010,1));
        tbl.push_back(mk(0,1,0, 4,1,0,0, 0,0, 0,0, 0,'h0000,0));
        tbl.push_back(mk(1,1,0, 4,1,0,0, 0,0, 0,0, 0,'h0000,0));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i]);
            step(st);
            chk("tbl_stall", 32'(st), 32'(tbl[i].exp_stall));
            chk("tbl_mask", 32'(pending_mask), 32'(tbl[i].exp_mask));
            chk("tbl_sb_err", 32'(sb_err), 32'(tbl[i].exp_err));
            if (i == 4)  chk("load_use_stall_count", 32'(stall_count), 32'd3);
            if (i == 29) chk("reset_stall_count", 32'(stall_count), 32'd0);
            $display("row %0d: rst_n=%0b stall=%0b mask=%04h cnt=%0d err=%0b",
                     i, tbl[i].rn, st, pending_mask, stall_count, sb_err);
        end

        for (int i = 0; i < 600; i++) begin
            rv.rn     = ($urandom_range(0, 63) != 0);
            rv.vl     = ($urandom_range(0, 3) != 0);
            rv.fl     = ($urandom_range(0, 7) == 0);
            rv.rs     = 4'($urandom_range(0, 7));
            rv.rt     = 4'($urandom_range(0, 7));
            rv.rd     = 4'($urandom_range(0, 7));
            rv.urs    = ($urandom_range(0, 1) == 1);
            rv.urt    = ($urandom_range(0, 1) == 1);
            rv.urd    = ($urandom_range(0, 3) == 0);
            rv.wen    = ($urandom_range(0, 1) == 1);
            rv.m2r    = ($urandom_range(0, 1) == 1);
            rv.wa     = 4'($urandom_range(0, 7));
            rv.wen_wb = ($urandom_range(0, 1) == 1);
            rv.m2r_wb = ($urandom_range(0, 1) == 1);
            rv.wa_wb  = 4'($urandom_range(0, 7));
            @(negedge clk);
            drive(rv);
            step(st);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 SHALL have parameter NREG, default 16: architectural register count; r0 is hardwired zero.
REQ-002 SHALL have port clk  in  1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  in  1: reset, synchronous and active-low.
REQ-004 SHALL have ports rs_id, rt_id, rd_id  in  4 each: ID-stage source fields inst[7:4], inst[3:0] and inst[11:8].
REQ-005 SHALL have ports use_rs_id, use_rt_id, use_rd_id  in  1 each: ID instruction reads that field; use_rd_id is set for the store-data read.
REQ-006 SHALL have ports valid_id  in  1 and flush_id  in  1: ID slot holds a real instruction; flush_id squashes the ID instruction this cycle.
REQ-007 SHALL have ports rf_wen_id, mem2reg_id  in  1 each, and rf_waddr_id  in  4: write enable, load flag and destination of the ID instruction.
REQ-008 SHALL have ports rf_wen_memwb, mem2reg_memwb  in  1 each, and rf_waddr_memwb  in  4: the write-back stage write.
REQ-009 SHALL have port stall  out  1: hold PC and IF/ID this cycle.
REQ-010 SHALL have port bubble_idex  out  1: load a NOP into ID/EX at the next edge.
REQ-011 SHALL have ports pending_mask  out  NREG, stall_count  out  16, and sb_err  out  1: debug and status outputs.

Function
REQ-012 SHALL hold one 2-bit outstanding-load counter cnt[r] for each r in 1..NREG-1; cnt[0] SHALL be constant 0.
REQ-013 SHALL compute hazard combinationally from registered counters: valid_id & ~flush_id & (hit_rs | hit_rt | hit_rd).
REQ-014 SHALL define hit_x = use_x_id & (x_id != 0) & (cnt[x_id] != 0), so a read of r0 never stalls.
REQ-015 SHALL drive stall = bubble_idex = hazard in the same cycle, with zero-cycle detection latency.
REQ-016 SHALL assert issue = valid_id & ~flush_id & ~hazard & rf_wen_id & mem2reg_id & (rf_waddr_id != 0).
REQ-017 SHALL assert retire = rf_wen_memwb & mem2reg_memwb & (rf_waddr_memwb != 0).
REQ-018 SHALL increment cnt[rf_waddr_id] by 1 on issue.
REQ-019 SHALL decrement cnt[rf_waddr_memwb] by 1 on retire.
REQ-020 SHALL leave the counter unchanged when issue and retire target the same register in one cycle.
REQ-021 SHALL update both counters when issue and retire target different registers in one cycle.
REQ-022 SHALL hold the counter at 3 when issuing to a register whose count is already 3, and set sb_err.
REQ-023 SHALL hold the counter at 0 when retiring from a register whose count is 0, and set sb_err.
REQ-024 SHALL keep sb_err sticky until reset.
REQ-025 SHALL not count non-load writes (mem2reg=0), because the forwarding path covers them.
REQ-026 SHALL stall a reader until the cycle after its load retires: the register file has no write-to-read bypass, and cnt clears at the write-back edge.
REQ-027 SHALL suppress issue on flush_id; stall SHALL be 0 during a flush even if a hazard is present.
REQ-028 SHALL drive pending_mask[r] = (cnt[r] != 0), registered, with pending_mask[0] = 0.
REQ-029 SHALL increment stall_count by 1 on each cycle with stall = 1, saturating at 16'hFFFF.
REQ-030 SHALL produce no X on outputs when use_*_id = 0, regardless of the values of the *_id fields.

Reset
REQ-031 SHALL clear all cnt, pending_mask, stall_count and sb_err on the first rising clk edge with rst_n = 0.
REQ-032 SHALL force stall and bubble_idex to 0 combinationally while rst_n = 0.
REQ-033 SHALL, on reset during operation, discard all in-flight load tracking, with no stall in the first cycle after rst_n returns to 1.

Verification
REQ-034 SHALL check load-use: issue load r3 (cnt[3] 0->1), next ID reads r3 via rs -> stall = bubble = 1 until the retire edge for r3, then 0 the next cycle; stall_count = number of stalled cycles (3 for an ID->EX->MEM->WB spacing).
REQ-035 SHALL check r0: load to r0, then a read of r0 -> cnt unchanged, stall = 0.
REQ-036 SHALL check same-cycle events: issue r5 while r5 retires with cnt[5] = 1 -> cnt[5] stays 1 and pending_mask[5] = 1; issue r5 while r6 retires -> cnt[5] +1, cnt[6] -1.
REQ-037 SHALL check flush: hazard on rd (store data r7 pending) with flush_id = 1 -> stall = 0 and no counter change.
REQ-038 SHALL check error cases: retire r9 with cnt[9] = 0 -> sb_err = 1, sticky, cnt[9] = 0; four issues to r2 without retire -> cnt[2] = 3 and sb_err = 1.
REQ-039 SHALL check reset mid-stall: rst_n = 0 for one edge while stall = 1 -> all outputs 0, pending_mask = 0, stall_count = 0.
